register_file_rename: RTL and testbench

//  Architectural register file with Tomasulo rename state for the RISC-V core.

---
 rtl/register_file_rename.sv | 94 +++++++++
 tb/tb_register_file_rename.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_rename.sv
// Architectural register file with Tomasulo rename state (value/busy/tag per register).
// Reads are combinational and see a same-cycle commit of the pending producer.
module register_file_rename #(
    parameter int REG_COUNT = 32,
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             issue_valid_in,
    input  logic [4:0]       issue_rd_in,
    input  logic [TAG_W-1:0] issue_tag_in,
    input  logic [4:0]       rs1_in,
    input  logic [4:0]       rs2_in,
    output logic [XLEN-1:0]  rs1_value_out,
    output logic             rs1_busy_out,
    output logic [TAG_W-1:0] rs1_tag_out,
    output logic [XLEN-1:0]  rs2_value_out,
    output logic             rs2_busy_out,
    output logic [TAG_W-1:0] rs2_tag_out,
    input  logic             commit_valid_in,
    input  logic [4:0]       commit_rd_in,
    input  logic [TAG_W-1:0] commit_tag_in,
    input  logic [XLEN-1:0]  commit_value_in,
    input  logic             flush_in
);

    logic [XLEN-1:0]      value_q [REG_COUNT];
    logic [TAG_W-1:0]     tag_q   [REG_COUNT];
    logic [REG_COUNT-1:0] busy_q;

    logic commit_write;
    logic commit_match;
    logic issue_write;

    // x0 is never written, so it stays at its reset state of 0 / not busy.
    assign commit_write = commit_valid_in && (commit_rd_in != 5'd0);
    assign commit_match = busy_q[commit_rd_in] && (tag_q[commit_rd_in] == commit_tag_in);
    assign issue_write  = issue_valid_in && (issue_rd_in != 5'd0);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q <= '0;
        end else if (rdy_in) begin
            if (commit_write) begin
                value_q[commit_rd_in] <= commit_value_in;
                if (commit_match)
                    busy_q[commit_rd_in] <= 1'b0;
            end
            // A later assignment to the same busy bit wins, so issue overrides the commit clear.
            if (flush_in) begin
                busy_q <= '0;
            end else if (issue_write) begin
                busy_q[issue_rd_in] <= 1'b1;
                tag_q[issue_rd_in]  <= issue_tag_in;
            end
        end
    end

    logic [4:0]       rs_addr  [2];
    logic [XLEN-1:0]  rd_value [2];
    logic [1:0]       rd_busy;
    logic [TAG_W-1:0] rd_tag   [2];

    assign rs_addr[0] = rs1_in;
    assign rs_addr[1] = rs2_in;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_value[p] = value_q[rs_addr[p]];
            rd_busy[p]  = busy_q[rs_addr[p]];
            rd_tag[p]   = busy_q[rs_addr[p]] ? tag_q[rs_addr[p]] : '0;
            if (commit_valid_in && (commit_rd_in == rs_addr[p]) && busy_q[rs_addr[p]] &&
                (tag_q[rs_addr[p]] == commit_tag_in)) begin
                rd_value[p] = commit_value_in;
                rd_busy[p]  = 1'b0;
                rd_tag[p]   = '0;
            end
        end
    end

    assign rs1_value_out = rd_value[0];
    assign rs1_busy_out  = rd_busy[0];
    assign rs1_tag_out   = rd_tag[0];
    assign rs2_value_out = rd_value[1];
    assign rs2_busy_out  = rd_busy[1];
    assign rs2_tag_out   = rd_tag[1];

endmodule

// File: tb/tb_register_file_rename.sv
// Self-checking bench for register_file_rename: per-cycle model comparison plus directed literal checks.
module tb_register_file_rename;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             rdy_in;
    logic             issue_valid_in;
    logic [4:0]       issue_rd_in;
    logic [TAG_W-1:0] issue_tag_in;
    logic [4:0]       rs1_in;
    logic [4:0]       rs2_in;
    logic [XLEN-1:0]  rs1_value_out;
    logic             rs1_busy_out;
    logic [TAG_W-1:0] rs1_tag_out;
    logic [XLEN-1:0]  rs2_value_out;
    logic             rs2_busy_out;
    logic [TAG_W-1:0] rs2_tag_out;
    logic             commit_valid_in;
    logic [4:0]       commit_rd_in;
    logic [TAG_W-1:0] commit_tag_in;
    logic [XLEN-1:0]  commit_value_in;
    logic             flush_in;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    register_file_rename #(.REG_COUNT(32), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid_in(issue_valid_in), .issue_rd_in(issue_rd_in), .issue_tag_in(issue_tag_in),
        .rs1_in(rs1_in), .rs2_in(rs2_in),
        .rs1_value_out(rs1_value_out), .rs1_busy_out(rs1_busy_out), .rs1_tag_out(rs1_tag_out),
        .rs2_value_out(rs2_value_out), .rs2_busy_out(rs2_busy_out), .rs2_tag_out(rs2_tag_out),
        .commit_valid_in(commit_valid_in), .commit_rd_in(commit_rd_in),
        .commit_tag_in(commit_tag_in), .commit_value_in(commit_value_in),
        .flush_in(flush_in)
    );

    // Architectural view: committed value per register plus the ROB entry it is waiting on, if any.
    bit [XLEN-1:0]  m_value   [32];
    bit             m_pending [32];
    bit [TAG_W-1:0] m_owner   [32];

    function automatic void model_read(input logic [4:0] rs, output logic [XLEN-1:0] v,
                                       output logic b, output logic [TAG_W-1:0] t);
        v = (rs == 5'd0) ? '0 : m_value[rs];
        b = 1'b0;
        t = '0;
        if (rs != 5'd0 && m_pending[rs]) begin
            if (commit_valid_in && commit_rd_in == rs && commit_tag_in == m_owner[rs]) begin
                v = commit_value_in;
            end else begin
                b = 1'b1;
                t = m_owner[rs];
            end
        end
    endfunction

    always @(negedge rst_in) begin
        for (int i = 0; i < 32; i++) begin
            m_value[i]   = '0;
            m_pending[i] = 1'b0;
            m_owner[i]   = '0;
        end
    end

    always @(posedge clk_in) begin
        if (rst_in === 1'b1 && rdy_in === 1'b1) begin
            if (commit_valid_in && commit_rd_in != 5'd0) begin
                if (m_pending[commit_rd_in] && m_owner[commit_rd_in] == commit_tag_in)
                    m_pending[commit_rd_in] = 1'b0;
                m_value[commit_rd_in] = commit_value_in;
            end
            if (flush_in) begin
                for (int i = 0; i < 32; i++) m_pending[i] = 1'b0;
            end else if (issue_valid_in && issue_rd_in != 5'd0) begin
                m_pending[issue_rd_in] = 1'b1;
                m_owner[issue_rd_in]   = issue_tag_in;
            end
        end
    end

    always @(negedge clk_in) begin
        logic [XLEN-1:0]  ev;
        logic             eb;
        logic [TAG_W-1:0] et;
        model_read(rs1_in, ev, eb, et);
        checks++;
        if ({rs1_value_out, rs1_busy_out, rs1_tag_out} !== {ev, eb, et}) begin
            errors++;
            $display("[TB] FAIL model_rs1 t=%0t rs=%0d got val=%h busy=%b tag=%0d expected val=%h busy=%b tag=%0d",
                     $time, rs1_in, rs1_value_out, rs1_busy_out, rs1_tag_out, ev, eb, et);
        end
        model_read(rs2_in, ev, eb, et);
        checks++;
        if ({rs2_value_out, rs2_busy_out, rs2_tag_out} !== {ev, eb, et}) begin
            errors++;
            $display("[TB] FAIL model_rs2 t=%0t rs=%0d got val=%h busy=%b tag=%0d expected val=%h busy=%b tag=%0d",
                     $time, rs2_in, rs2_value_out, rs2_busy_out, rs2_tag_out, ev, eb, et);
        end
    end

    task automatic applyStimulus(input logic iv, input logic [4:0] ird, input logic [TAG_W-1:0] itag,
                                 input logic cv, input logic [4:0] crd, input logic [TAG_W-1:0] ctag,
                                 input logic [XLEN-1:0] cval, input logic fl, input logic rdy,
                                 input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk_in);
        #1;
        issue_valid_in  = iv;
        issue_rd_in     = ird;
        issue_tag_in    = itag;
        commit_valid_in = cv;
        commit_rd_in    = crd;
        commit_tag_in   = ctag;
        commit_value_in = cval;
        flush_in        = fl;
        rdy_in          = rdy;
        rs1_in          = r1;
        rs2_in          = r2;
        @(negedge clk_in);
        #1;
    endtask

    task automatic checkOutput(input string name, input bit port, input logic [XLEN-1:0] ev,
                               input logic eb, input logic [TAG_W-1:0] et);
        logic [XLEN-1:0]  av;
        logic             ab;
        logic [TAG_W-1:0] at;
        av = port ? rs2_value_out : rs1_value_out;
        ab = port ? rs2_busy_out  : rs1_busy_out;
        at = port ? rs2_tag_out   : rs1_tag_out;
        checks++;
        if ({av, ab, at} !== {ev, eb, et}) begin
            errors++;
            $display("[TB] FAIL %s got val=%h busy=%b tag=%0d expected val=%h busy=%b tag=%0d",
                     name, av, ab, at, ev, eb, et);
        end
    endtask

    initial begin
        rst_in = 1'b0;
        rdy_in = 1'b1;
        issue_valid_in = 1'b0; issue_rd_in = '0; issue_tag_in = '0;
        commit_valid_in = 1'b0; commit_rd_in = '0; commit_tag_in = '0; commit_value_in = '0;
        flush_in = 1'b0; rs1_in = 5'd5; rs2_in = 5'd31;
        repeat (2) @(negedge clk_in);
        #1;
        checkOutput("reset_rs1", 1'b0, 32'h0, 1'b0, 5'd0);
        checkOutput("reset_rs2", 1'b1, 32'h0, 1'b0, 5'd0);
        rst_in = 1'b1;

        applyStimulus(1'b1, 5'd5, 5'd3, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd5, 5'd0);
        checkOutput("issue_same_cycle_old", 1'b0, 32'h0, 1'b0, 5'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd5, 5'd0);
        checkOutput("renamed_busy", 1'b0, 32'h0, 1'b1, 5'd3);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 5'd3, 32'hDEADBEEF, 1'b0, 1'b1, 5'd5, 5'd0);
        checkOutput("commit_bypass", 1'b0, 32'hDEADBEEF, 1'b0, 5'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd5, 5'd0);
        checkOutput("commit_written", 1'b0, 32'hDEADBEEF, 1'b0, 5'd0);

        applyStimulus(1'b1, 5'd7, 5'd1, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd7, 5'd0);
        applyStimulus(1'b1, 5'd7, 5'd2, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd7, 5'd0);
        checkOutput("rename_old_owner", 1'b0, 32'h0, 1'b1, 5'd1);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 5'd1, 32'h11, 1'b0, 1'b1, 5'd7, 5'd0);
        checkOutput("stale_commit_no_bypass", 1'b0, 32'h0, 1'b1, 5'd2);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd7, 5'd0);
        checkOutput("stale_commit_value", 1'b0, 32'h11, 1'b1, 5'd2);

        applyStimulus(1'b1, 5'd9, 5'd4, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd9, 5'd0);
        checkOutput("issue_read_same_cycle", 1'b0, 32'h0, 1'b0, 5'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd9, 5'd0);
        checkOutput("issue_read_next_cycle", 1'b0, 32'h0, 1'b1, 5'd4);

        applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd1, 5'd0, 32'hA1, 1'b0, 1'b1, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 5'd0, 32'hA3, 1'b0, 1'b1, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd1, 5'd5, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd2, 5'd6, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd3, 5'd7, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd2, 5'd9, 32'h55, 1'b1, 1'b1, 5'd2, 5'd1);
        checkOutput("pre_flush_x2", 1'b0, 32'h0, 1'b1, 5'd6);
        checkOutput("pre_flush_x1", 1'b1, 32'hA1, 1'b1, 5'd5);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd1, 5'd2);
        checkOutput("flush_x1", 1'b0, 32'hA1, 1'b0, 5'd0);
        checkOutput("flush_x2_commit", 1'b1, 32'h55, 1'b0, 5'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd3, 5'd9);
        checkOutput("flush_x3", 1'b0, 32'hA3, 1'b0, 5'd0);
        checkOutput("flush_x9", 1'b1, 32'h0, 1'b0, 5'd0);

        applyStimulus(1'b1, 5'd10, 5'd8, 1'b1, 5'd10, 5'd0, 32'h77, 1'b0, 1'b1, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd10, 5'd0);
        checkOutput("commit_issue_same_rd", 1'b0, 32'h77, 1'b1, 5'd8);
        applyStimulus(1'b1, 5'd11, 5'd12, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd11, 5'd12, 32'hCAFE, 1'b0, 1'b1, 5'd0, 5'd11);
        checkOutput("bypass_rs2", 1'b1, 32'hCAFE, 1'b0, 5'd0);

        applyStimulus(1'b1, 5'd0, 5'd3, 1'b1, 5'd0, 5'd3, 32'h1234, 1'b0, 1'b1, 5'd0, 5'd0);
        checkOutput("x0_same_cycle", 1'b0, 32'h0, 1'b0, 5'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd0, 5'd0);
        checkOutput("x0_after", 1'b0, 32'h0, 1'b0, 5'd0);
        applyStimulus(1'b1, 5'd4, 5'd1, 1'b1, 5'd4, 5'd0, 32'h99, 1'b1, 1'b0, 5'd4, 5'd10);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd4, 5'd10);
        checkOutput("paused_x4", 1'b0, 32'h0, 1'b0, 5'd0);
        checkOutput("paused_no_flush", 1'b1, 32'h77, 1'b1, 5'd8);

        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd10, 5'd5);
        #1;
        rst_in = 1'b0;
        #1;
        checkOutput("async_reset_rs1", 1'b0, 32'h0, 1'b0, 5'd0);
        checkOutput("async_reset_rs2", 1'b1, 32'h0, 1'b0, 5'd0);
        @(negedge clk_in);
        #1;
        rst_in = 1'b1;
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd5, 5'd10);
        checkOutput("post_reset_x5", 1'b0, 32'h0, 1'b0, 5'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
